// File: rtl/cpu_io_port_if.sv
// cpu_io_port_if: CPU-side bus of the 6510 on-chip I/O port.
// Master drives strobe/address/data, slave returns read data and select.
interface cpu_io_port_if;
    logic        cpu_en;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        we;
    logic [7:0]  dout;
    logic        sel;

    modport master (
        output cpu_en, addr, din, we,
        input  dout, sel
    );

    modport slave (
        input  cpu_en, addr, din, we,
        output dout, sel
    );
endinterface

// File: rtl/cpu_io_port.sv
// cpu_io_port: 6510 I/O port at $0000/$0001 with PLA/cassette lines.
// Bits 6/7 keep a decaying floating charge when left as inputs.
module cpu_io_port #(
    parameter int unsigned FADE_CYCLES = 350000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    cpu_io_port_if.slave bus,
    input  logic [5:0]  pin_in,
    output logic [5:0]  port_o,
    output logic        loram_n,
    output logic        hiram_n,
    output logic        charen_n,
    output logic        cass_wr,
    output logic        cass_motor
);

    localparam logic [CNT_W-1:0] FADE_LOAD = CNT_W'(FADE_CYCLES);

    logic [7:0]            ddr_q, ddr_d;
    logic [7:0]            data_q, data_d;
    logic [1:0]            fade_q, fade_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

    logic       wr_ddr;
    logic       wr_data;
    logic [7:0] rd_port;

    // Address decode and write strobes for the two port registers
    always_comb begin
        bus.sel = (bus.addr[15:1] == 15'd0);
        wr_ddr  = bus.cpu_en & bus.we & bus.sel & ~bus.addr[0];
        wr_data = bus.cpu_en & bus.we & bus.sel & bus.addr[0];
        ddr_d   = wr_ddr  ? bus.din : ddr_q;
        data_d  = wr_data ? bus.din : data_q;
    end

    // Pin resolution: outputs drive data, inputs are pulled high
    always_comb begin
        port_o     = (ddr_q[5:0] & data_q[5:0]) | ~ddr_q[5:0];
        loram_n    = port_o[0];
        hiram_n    = port_o[1];
        charen_n   = port_o[2];
        cass_wr    = port_o[3];
        cass_motor = port_o[5];
    end

    // Read mux: $0000 returns ddr, $0001 returns resolved levels
    always_comb begin
        rd_port = (ddr_q & data_q)
                | (~ddr_q & {fade_q, port_o & pin_in});
        if (!bus.sel) begin
            bus.dout = 8'h00;
        end else if (bus.addr[0]) begin
            bus.dout = rd_port;
        end else begin
            bus.dout = ddr_q;
        end
    end

    // Floating charge on bits 6/7, evaluated after this tick's write
    always_comb begin
        fade_d = fade_q;
        cnt_d  = cnt_q;
        if (bus.cpu_en) begin
            for (int k = 0; k < 2; k++) begin
                if (ddr_d[6+k]) begin
                    fade_d[k] = data_d[6+k];
                    cnt_d[k]  = FADE_LOAD;
                end else if (fade_q[k]) begin
                    if (cnt_q[k] != '0) begin
                        cnt_d[k] = cnt_q[k] - CNT_W'(1);
                    end else begin
                        fade_d[k] = 1'b0;
                    end
                end
            end
        end
    end

    // Port state registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ddr_q  <= 8'h00;
            data_q <= 8'h00;
            fade_q <= 2'b00;
            cnt_q  <= '0;
        end else begin
            ddr_q  <= ddr_d;
            data_q <= data_d;
            fade_q <= fade_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cpu_io_port.sv
// tb_cpu_io_port: directed vectors with a queue-based scoreboard.
// The driver queues expectations; a negedge monitor checks them.
module tb_cpu_io_port;

    typedef struct {
        string       name;
        logic [19:0] v;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] pin_in;
    logic [5:0] port_o;
    logic       loram_n, hiram_n, charen_n, cass_wr, cass_motor;
    bit         chk;
    int         total;
    int         bad;
    exp_t       q[$];

    cpu_io_port_if bus_if ();

    cpu_io_port #(
        .FADE_CYCLES (8),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if),
        .pin_in     (pin_in),
        .port_o     (port_o),
        .loram_n    (loram_n),
        .hiram_n    (hiram_n),
        .charen_n   (charen_n),
        .cass_wr    (cass_wr),
        .cass_motor (cass_motor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] mk(input logic s, input logic [5:0] p,
                                       input logic [7:0] d);
        return {p[5], p[3], p[2], p[1], p[0], s, p, d};
    endfunction

    // Monitor: whenever a check is flagged, pop and compare
    always @(negedge clk) begin
        if (chk) begin
            logic [19:0] act;
            exp_t        e;
            act = {cass_motor, cass_wr, charen_n, hiram_n, loram_n,
                   bus_if.sel, port_o, bus_if.dout};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL monitor: no expectation queued, got %h", act);
            end else begin
                e = q.pop_front();
                if (act !== e.v) begin
                    bad++;
                    $display("FAIL %s: got %h want %h", e.name, act, e.v);
                end
            end
        end
    end

    task automatic step(input bit en, input bit w, input logic [15:0] a,
                        input logic [7:0] d, input logic [5:0] pin,
                        input bit c, input string nm, input logic es,
                        input logic [5:0] ep, input logic [7:0] ed);
        exp_t e;
        bus_if.cpu_en = en;
        bus_if.we     = w;
        bus_if.addr   = a;
        bus_if.din    = d;
        pin_in        = pin;
        if (c) begin
            e.name = nm;
            e.v    = mk(es, ep, ed);
            q.push_back(e);
        end
        chk = c;
        @(posedge clk);
        #1;
        chk = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        total = 0;
        bad   = 0;
        chk   = 1'b0;
        rst_n = 1'b0;
        bus_if.cpu_en = 1'b0;
        bus_if.we     = 1'b0;
        bus_if.addr   = 16'h0000;
        bus_if.din    = 8'h00;
        pin_in        = 6'h3F;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        step(0, 0, 16'h0000, 8'h00, 6'h3F, 1, "rst_ddr", 1, 6'h3F, 8'h00);
        step(0, 0, 16'h0001, 8'h00, 6'h3F, 1, "rst_data", 1, 6'h3F, 8'h3F);
        rst_n = 1'b1;
        step(0, 0, 16'h0002, 8'h00, 6'h3F, 1, "rst_idle", 0, 6'h3F, 8'h00);

        // KERNAL configuration
        step(1, 1, 16'h0000, 8'h2F, 6'h3F, 0, "", 0, 6'h00, 8'h00);
        step(1, 1, 16'h0001, 8'h37, 6'h3F, 1, "krn_old", 1, 6'h10, 8'h10);
        step(1, 0, 16'h0000, 8'h00, 6'h3F, 1, "krn_ddr", 1, 6'h37, 8'h2F);
        step(1, 0, 16'h0001, 8'h00, 6'h3F, 1, "krn_37", 1, 6'h37, 8'h37);
        step(1, 1, 16'h0001, 8'h35, 6'h3F, 1, "krn_wr35", 1, 6'h37, 8'h37);
        step(1, 0, 16'h0001, 8'h00, 6'h3F, 1, "krn_35", 1, 6'h35, 8'h35);

        // all-RAM
        step(1, 1, 16'h0001, 8'h30, 6'h3F, 1, "ram_wr", 1, 6'h35, 8'h35);
        step(1, 0, 16'h0001, 8'h00, 6'h3F, 1, "ram_30", 1, 6'h30, 8'h30);
        step(1, 0, 16'h0001, 8'h00, 6'h2F, 1, "ram_pin4", 1, 6'h30, 8'h20);

        // gating and address qualification
        step(0, 1, 16'h0001, 8'hFF, 6'h3F, 1, "gate_en0", 1, 6'h30, 8'h30);
        step(1, 1, 16'h0002, 8'hFF, 6'h3F, 1, "gate_a2", 0, 6'h30, 8'h00);
        step(1, 0, 16'h0001, 8'h00, 6'h3F, 1, "gate_data", 1, 6'h30, 8'h30);
        step(1, 0, 16'h0000, 8'h00, 6'h3F, 1, "gate_ddr", 1, 6'h30, 8'h2F);
        step(1, 0, 16'h0101, 8'h00, 6'h3F, 1, "gate_a101", 0, 6'h30, 8'h00);

        // pull-ups with all inputs
        step(1, 1, 16'h0000, 8'h00, 6'h3F, 1, "pu_wr", 1, 6'h30, 8'h2F);
        step(1, 0, 16'h0001, 8'h00, 6'h2F, 1, "pu_read", 1, 6'h3F, 8'h2F);

        // fade: output-1 then input, charge held for 9 ticks
        step(1, 1, 16'h0000, 8'hC0, 6'h3F, 0, "", 0, 6'h00, 8'h00);
        step(1, 1, 16'h0001, 8'hC0, 6'h3F, 0, "", 0, 6'h00, 8'h00);
        step(1, 1, 16'h0000, 8'h00, 6'h3F, 1, "fade_sw", 1, 6'h3F, 8'hC0);
        for (int i = 1; i <= 8; i++) begin
            if (i == 4)
                step(1, 1, 16'h0001, 8'h00, 6'h3F, 1, "fade_wrin",
                     1, 6'h3F, 8'hFF);
            else
                step(1, 0, 16'h0001, 8'h00, 6'h3F, 1, "fade_hold",
                     1, 6'h3F, 8'hFF);
        end
        step(1, 0, 16'h0001, 8'h00, 6'h3F, 1, "fade_gone", 1, 6'h3F, 8'h3F);
        step(1, 0, 16'h0001, 8'h00, 6'h3F, 1, "fade_stay", 1, 6'h3F, 8'h3F);

        // fade interrupted by switching back to output
        step(1, 1, 16'h0001, 8'hC0, 6'h3F, 0, "", 0, 6'h00, 8'h00);
        step(1, 1, 16'h0000, 8'hC0, 6'h3F, 0, "", 0, 6'h00, 8'h00);
        step(1, 1, 16'h0000, 8'h00, 6'h3F, 0, "", 0, 6'h00, 8'h00);
        for (int i = 0; i < 4; i++)
            step(1, 0, 16'h0001, 8'h00, 6'h3F, 1, "re_mid", 1, 6'h3F, 8'hFF);
        step(1, 1, 16'h0000, 8'hC0, 6'h3F, 1, "re_on", 1, 6'h3F, 8'h00);
        step(1, 0, 16'h0001, 8'h00, 6'h3F, 1, "re_out", 1, 6'h3F, 8'hFF);
        step(1, 1, 16'h0000, 8'h00, 6'h3F, 1, "re_sw", 1, 6'h3F, 8'hC0);
        for (int i = 0; i < 3; i++)
            step(0, 0, 16'h0001, 8'h00, 6'h3F, 1, "frz", 1, 6'h3F, 8'hFF);
        for (int i = 0; i < 8; i++)
            step(1, 0, 16'h0001, 8'h00, 6'h3F, 1, "re_hold", 1, 6'h3F, 8'hFF);
        step(1, 0, 16'h0001, 8'h00, 6'h3F, 1, "re_gone", 1, 6'h3F, 8'h3F);

        // asynchronous reset in the middle of a fade
        step(1, 1, 16'h0000, 8'hEF, 6'h3F, 0, "", 0, 6'h00, 8'h00);
        step(1, 1, 16'h0000, 8'h00, 6'h3F, 0, "", 0, 6'h00, 8'h00);
        step(1, 0, 16'h0001, 8'h00, 6'h3F, 1, "pre_rst", 1, 6'h3F, 8'hFF);
        bus_if.cpu_en = 1'b0;
        bus_if.we     = 1'b0;
        rst_n  = 1'b0;
        e.name = "rst_async";
        e.v    = mk(1'b1, 6'h3F, 8'h3F);
        q.push_back(e);
        chk = 1'b1;
        @(negedge clk);
        #1;
        chk = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 16'h0000, 8'h00, 6'h3F, 1, "post_rst", 1, 6'h3F, 8'h00);

        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d left want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
